// File: rtl/foc_xform_seq.sv
// foc_xform_seq: starts Clarke and CORDIC together on trig, then Park, and captures D/Q with a valid pulse.
// Latency trig->valid = 3 + Tcc + Tpark cycles; a trig while busy is dropped and flagged as overrun.
// Define FOC_SEQ_WDOG_EN to enable the per-state watchdog that drives timeout/stage_err.
module foc_xform_seq #(
    parameter int D_WIDTH     = 18,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               trig,
    output logic               clarke_start,
    input  logic               clarke_done,
    output logic               cordic_start,
    input  logic               cordic_done,
    output logic               park_start,
    input  logic               park_done,
    input  logic [D_WIDTH-1:0] park_d,
    input  logic [D_WIDTH-1:0] park_q,
    output logic [D_WIDTH-1:0] d_out,
    output logic [D_WIDTH-1:0] q_out,
    output logic               valid,
    output logic               busy,
    output logic               overrun,
    output logic               timeout,
    output logic [1:0]         stage_err,
    input  logic               err_clr
);

    if (TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("TIMEOUT_CYC must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, CC_WAIT, PARK_WAIT} state_t;

    state_t state, state_nx;
    logic   cl_f, co_f, cl_f_nx, co_f_nx;
    logic   cl_eff, co_eff;
    logic   clarke_start_nx, cordic_start_nx, park_start_nx, valid_nx, capture;
    logic   overrun_nx;

    // A done arriving this cycle counts as if its flag were already set.
    assign cl_eff = cl_f | clarke_done;
    assign co_eff = co_f | cordic_done;
    assign busy   = (state != IDLE);

`ifdef FOC_SEQ_WDOG_EN
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] wcnt, wcnt_nx;
    logic          expire, abort;
    logic [1:0]    abort_code;
    logic          timeout_nx;
    logic [1:0]    stage_err_nx;

    assign expire = (wcnt == CW'(TIMEOUT_CYC - 1));
`endif

    always_comb begin
        state_nx        = state;
        cl_f_nx         = cl_f;
        co_f_nx         = co_f;
        clarke_start_nx = 1'b0;
        cordic_start_nx = 1'b0;
        park_start_nx   = 1'b0;
        valid_nx        = 1'b0;
        capture         = 1'b0;
`ifdef FOC_SEQ_WDOG_EN
        wcnt_nx    = wcnt + CW'(1);
        abort      = 1'b0;
        abort_code = 2'd0;
`endif
        case (state)
            IDLE: begin
`ifdef FOC_SEQ_WDOG_EN
                wcnt_nx = '0;
`endif
                if (trig) begin
                    state_nx        = CC_WAIT;
                    clarke_start_nx = 1'b1;
                    cordic_start_nx = 1'b1;
                    cl_f_nx         = 1'b0;
                    co_f_nx         = 1'b0;
                end
            end
            CC_WAIT: begin
                cl_f_nx = cl_eff;
                co_f_nx = co_eff;
                if (cl_eff && co_eff) begin
                    state_nx      = PARK_WAIT;
                    park_start_nx = 1'b1;
`ifdef FOC_SEQ_WDOG_EN
                    wcnt_nx = '0;
                end else if (expire) begin
                    state_nx   = IDLE;
                    abort      = 1'b1;
                    abort_code = !cl_eff ? 2'd1 : 2'd2;
`endif
                end
            end
            PARK_WAIT: begin
                if (park_done) begin
                    state_nx = IDLE;
                    valid_nx = 1'b1;
                    capture  = 1'b1;
`ifdef FOC_SEQ_WDOG_EN
                end else if (expire) begin
                    state_nx   = IDLE;
                    abort      = 1'b1;
                    abort_code = 2'd3;
`endif
                end
            end
            default: state_nx = IDLE;
        endcase

        // Set events take priority over err_clr.
        overrun_nx = overrun;
        if (trig && busy) overrun_nx = 1'b1;
        else if (err_clr) overrun_nx = 1'b0;
`ifdef FOC_SEQ_WDOG_EN
        timeout_nx   = timeout;
        stage_err_nx = stage_err;
        if (abort) begin
            timeout_nx   = 1'b1;
            stage_err_nx = abort_code;
        end else if (err_clr) begin
            timeout_nx   = 1'b0;
            stage_err_nx = 2'd0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state        <= IDLE;
            cl_f         <= 1'b0;
            co_f         <= 1'b0;
            clarke_start <= 1'b0;
            cordic_start <= 1'b0;
            park_start   <= 1'b0;
            valid        <= 1'b0;
            d_out        <= '0;
            q_out        <= '0;
            overrun      <= 1'b0;
        end else begin
            state        <= state_nx;
            cl_f         <= cl_f_nx;
            co_f         <= co_f_nx;
            clarke_start <= clarke_start_nx;
            cordic_start <= cordic_start_nx;
            park_start   <= park_start_nx;
            valid        <= valid_nx;
            overrun      <= overrun_nx;
            if (capture) begin
                d_out <= park_d;
                q_out <= park_q;
            end
        end
    end

`ifdef FOC_SEQ_WDOG_EN
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wcnt      <= '0;
            timeout   <= 1'b0;
            stage_err <= 2'd0;
        end else begin
            wcnt      <= wcnt_nx;
            timeout   <= timeout_nx;
            stage_err <= stage_err_nx;
        end
    end
`else
    assign timeout   = 1'b0;
    assign stage_err = 2'd0;
`endif

endmodule

// File: doc/foc_xform_seq.md
# foc_xform_seq

Sequencer for the field-oriented-control current-transform chain. On each sample trigger it starts the Clarke and CORDIC blocks in parallel and waits for both to finish. It then starts the Park block and captures its D/Q result into holding registers with a one-cycle valid pulse. It sits between the PWM/ADC sample timing and the current controllers, and detects overruns and (optionally) hung stages.

## Interface
- D_WIDTH, 18, width of captured D/Q words (signed, same format as Park output)
- TIMEOUT_CYC, 64, max cycles allowed per wait state before watchdog abort (≥2)

- clk  in  1  clock
- rstb  in  1  reset, asynchronous, active-low
- trig  in  1  sample trigger, single-cycle pulse
- clarke_start  out  1  start pulse to Clarke block
- clarke_done  in  1  Clarke completion, single-cycle pulse
- cordic_start  out  1  start pulse to CORDIC sin/cos block
- cordic_done  in  1  CORDIC completion, single-cycle pulse
- park_start  out  1  start pulse to Park block
- park_done  in  1  Park completion, single-cycle pulse
- park_d  in  D_WIDTH  Park D result, valid when park_done=1
- park_q  in  D_WIDTH  Park Q result, valid when park_done=1
- d_out  out  D_WIDTH  last captured D (signed)
- q_out  out  D_WIDTH  last captured Q (signed)
- valid  out  1  one-cycle pulse: new d_out/q_out
- busy  out  1  high whenever state ≠ IDLE
- overrun  out  1  sticky: trig arrived while busy
- timeout  out  1  sticky: watchdog abort occurred
- stage_err  out  2  sticky code of stage that timed out: 0 none, 1 Clarke, 2 CORDIC, 3 Park
- err_clr  in  1  clears overrun, timeout, stage_err

## Operation
- States: IDLE, CC_WAIT, PARK_WAIT. All outputs are registered.
- IDLE + trig:
  - Next cycle: clarke_start=1, cordic_start=1 (one cycle each), state→CC_WAIT.
  - Flags cl_f and co_f clear.
- CC_WAIT:
  - clarke_done sets cl_f; cordic_done sets co_f. Both may arrive in the same cycle, in either order.
  - Repeat done pulses after a flag is set are ignored.
  - When cl_f and co_f are both set (including the cycle the second done arrives): next cycle park_start=1, state→PARK_WAIT.
- PARK_WAIT + park_done:
  - Next cycle: d_out←park_d, q_out←park_q, valid=1, state→IDLE.
- trig in the valid cycle (already IDLE) is accepted normally.
- trig while busy:
  - Ignored, no restart.
  - overrun←1.
- done pulses arriving in IDLE, or for a stage not being waited on (e.g. park_done in CC_WAIT): ignored.
- d_out/q_out hold their value until the next successful capture; they are not cleared on abort.
- err_clr:
  - Clears overrun, timeout and stage_err next cycle.
  - If a set event occurs in the same cycle, set wins.
- Reset values: all outputs 0, state IDLE, flags 0, watchdog count 0.
- Reset mid-operation: the in-flight sequence is abandoned. Late done pulses after reset arrive in IDLE and are ignored.

## Timing
- trig→clarke_start/cordic_start: 1 cycle.
- Last CC done→park_start: 1 cycle.
- park_done→valid: 1 cycle.
- Total latency trig→valid = 3 + Tcc + Tpark cycles.
  - Tcc = cycles from start to the later of the two CC done pulses.
  - Tpark = cycles from park_start to park_done.
- Sub-blocks with zero-latency done (done in the cycle after start) are supported.
- Minimum trig spacing without overrun = total latency.

## Configuration
- FOC_SEQ_WDOG_EN defined:
  - Per-state counter cleared on entry to CC_WAIT/PARK_WAIT; increments each cycle in the state.
  - If it reaches TIMEOUT_CYC−1 with the stage incomplete:
    - state→IDLE next cycle, no valid.
    - timeout←1.
    - stage_err←1 if cl_f=0, else 2 if co_f=0 (Clarke reported first if both are missing), or 3 in PARK_WAIT.
  - Completion in the same cycle as expiry counts as completion.
- FOC_SEQ_WDOG_EN undefined:
  - No counter; wait states wait indefinitely.
  - timeout and stage_err are tied to 0.

## Test plan
- Nominal run:
  - Stimulus: trig; clarke_done at +4, cordic_done at +10, park_done 3 cycles after park_start, with park_d=18'h01234, park_q=18'h3FF00.
  - Expected: park_start exactly 1 cycle after cordic_done; valid 1 cycle after park_done; d_out=18'h01234, q_out=18'h3FF00; busy falls with valid.
- CC dones in the same cycle:
  - Stimulus: clarke_done and cordic_done both at +2; also repeat clarke_done.
  - Expected: single park_start 1 cycle later; the repeated done has no effect.
- Overrun:
  - Stimulus: trig again while in PARK_WAIT.
  - Expected: overrun=1; sequence completes once with a single valid.
  - Stimulus: err_clr.
  - Expected: overrun=0.
- Watchdog (FOC_SEQ_WDOG_EN, TIMEOUT_CYC=16):
  - Stimulus: withhold cordic_done.
  - Expected: timeout=1, stage_err=2, return to IDLE, no valid, d_out unchanged.
  - Stimulus: rerun with park_done withheld.
  - Expected: stage_err=3.
- Reset mid-PARK_WAIT:
  - Stimulus: rstb low, then park_done after release.
  - Expected: all outputs 0; late park_done ignored; the next trig runs normally.
- Back-to-back:
  - Stimulus: trig in the valid cycle.
  - Expected: accepted; starts pulse next cycle; no overrun.
